fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the program counter register and IF/ID latch. Decides each cycle whether the PC advances (`pc_wd`) and whether IF/ID captures, using the instruction-memory wait-state count, a four-source stall bus, and a branch flush/redirect. Sits between the hazard/branch logic and the PC register. Also keeps issue and stall performance counters.

## Interface
- `MEM_WAIT`, default 1: instruction-memory wait states per fetch, range 0-15.
- `ADDR_W`, default 32: instruction address width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ce`  in  1  chip enable from the PC register; low means the fetch unit is held off.
- `stall_req`  in  4  stall requests [0]=ID, [1]=EX, [2]=MEM, [3]=WB; any bit set means stall.
- `flush`  in  1  branch taken, one-cycle pulse.
- `branch_target`  in  ADDR_W  redirect address, valid with `flush`.
- `pc_wd`  out  1  PC advance strobe, one cycle per issued fetch.
- `ifid_wd`  out  1  IF/ID write enable, same cycle as `pc_wd`.
- `ifid_flush`  out  1  clears IF/ID, one-cycle pulse.
- `redirect_valid`  out  1  load `redirect_addr` into the PC, one-cycle pulse.
- `redirect_addr`  out  ADDR_W  registered copy of `branch_target`.
- `busy`  out  1  high in every state except IDLE.
- `issue_cnt`  out  32  count of `pc_wd` pulses; wraps.
- `stall_cycles`  out  16  cycles spent in STALL; saturates at 0xFFFF.

## Operation
- All outputs are registered. A decision made at edge N is visible from N to N+1.
- Reset (`rst`=0, asynchronous) sets state IDLE, wait counter `wcnt` to `MEM_WAIT`, and every output to 0, including `redirect_addr`, `issue_cnt` and `stall_cycles`.
- Conditions are evaluated at each edge in this priority order: `ce`=0 > `flush` > stall > wait/issue.
- **IDLE:** outputs 0. Go to FETCH when `ce`=1, with `wcnt` loaded to `MEM_WAIT`.
- **FETCH:**
  - If `wcnt`≠0, decrement it; no strobes.
  - If `wcnt`=0 and no stall, register `pc_wd`=`ifid_wd`=1, reload `wcnt` to `MEM_WAIT`, and increment `issue_cnt`.
  - If `wcnt`=0 and any stall bit is set, go to STALL with no strobe.
  - With `MEM_WAIT`=0, `pc_wd` is high every cycle while unstalled.
- **STALL:**
  - `pc_wd`=`ifid_wd`=0; `stall_cycles` increments each cycle spent here, saturating.
  - When `stall_req`=0, go to FETCH with `wcnt`=0, so the fetch issues at the next edge.
  - A stall only takes effect at the `wcnt`=0 boundary. A stall raised mid-wait is sampled when the wait completes.
- **Flush** (from FETCH or STALL):
  - Register `redirect_valid`=1, `ifid_flush`=1, `redirect_addr`=`branch_target`, with `pc_wd`=`ifid_wd`=0. Any fetch due on that edge is dropped.
  - Reload `wcnt` to `MEM_WAIT`.
  - Next state is STALL if any `stall_req` bit is set, else FETCH.
- `ce`=0 in any state forces IDLE at the next edge. All strobes are 0 from then on. Counters and `redirect_addr` are held.
- Strobes never last more than one cycle. `pc_wd` and `redirect_valid` are never high together.

## Timing
- Steady state, unstalled: one `pc_wd` every `MEM_WAIT`+1 cycles.
- Reset release to first `pc_wd`, with `ce`=1 and no stall: IDLE→FETCH takes 1 edge, the wait takes `MEM_WAIT` edges, and the issue takes 1 edge. With `MEM_WAIT`=1, the strobe is high in cycle 3.
- Stall release to `pc_wd`: 1 cycle after `stall_req` returns to 0.
- `flush` to `redirect_valid`: 1 cycle.
- After a redirect, the first `pc_wd` is `MEM_WAIT`+1 cycles later.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Any strobe in progress drops in the same cycle.

## Test plan
- **Reset/run:** `MEM_WAIT`=1, `ce`=1, no stalls, run 20 cycles → `pc_wd` pulses every 2nd cycle, first pulse at cycle 3, and `issue_cnt`=9 at the end.
- **Zero-wait stall:** `MEM_WAIT`=0, pulse `stall_req`=4'b0100 for 5 cycles → `pc_wd` is low for 5 cycles, `stall_cycles`=5, and `pc_wd` resumes 1 cycle after release.
- **Flush vs issue:** assert `flush` with `branch_target`=0x0000_1000 on the edge where `wcnt`=0 → `redirect_valid`=1 and `ifid_flush`=1 with `redirect_addr`=0x1000, `pc_wd`=0 that cycle, and the next `pc_wd` comes `MEM_WAIT`+1 cycles later.
- **Flush during stall:** `stall_req`=4'b0001 held, `flush` pulsed → redirect pulse, state stays STALL, no `pc_wd` until the stall clears.
- **`ce` and reset:** drop `ce` mid-wait → IDLE, all strobes 0 from the next cycle, counters held. Assert `rst`=0 between edges → all outputs 0 immediately, counters cleared.
- **Saturation:** force a stall for 70000 cycles → `stall_cycles` holds at 0xFFFF with no wrap.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: paces PC advance / IF/ID capture against instruction-memory wait
// states, stalls and branch redirects, and keeps issue/stall performance counters.
module fetch_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic [3:0]        i_stall_req,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_pc_wd,
  output logic              o_ifid_wd,
  output logic              o_ifid_flush,
  output logic              o_redirect_valid,
  output logic [ADDR_W-1:0] o_redirect_addr,
  output logic              o_busy,
  output logic [31:0]       o_issue_cnt,
  output logic [15:0]       o_stall_cycles
);

  localparam logic [3:0] WaitInit = 4'(MEM_WAIT);

  typedef enum logic [1:0] {StIdle, StFetch, StStall} state_e;

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_wcnt, w_wcnt_nxt;
  logic                r_pc_wd, w_pc_wd_nxt;
  logic                r_ifid_flush, w_ifid_flush_nxt;
  logic                r_redirect_valid, w_redirect_valid_nxt;
  logic [ADDR_W-1:0]   r_redirect_addr, w_redirect_addr_nxt;
  logic                r_busy, w_busy_nxt;
  logic [31:0]         r_issue_cnt, w_issue_cnt_nxt;
  logic [15:0]         r_stall_cycles, w_stall_cycles_nxt;
  logic                w_stall;

  assign w_stall = |i_stall_req;

  always_comb begin
    w_state_nxt          = r_state;
    w_wcnt_nxt           = r_wcnt;
    w_pc_wd_nxt          = 1'b0;
    w_ifid_flush_nxt     = 1'b0;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_addr_nxt  = r_redirect_addr;
    w_issue_cnt_nxt      = r_issue_cnt;
    w_stall_cycles_nxt   = r_stall_cycles;

    if (!i_ce) begin
      w_state_nxt = StIdle;
    end else begin
      if (r_state == StStall && r_stall_cycles != 16'hFFFF) begin
        w_stall_cycles_nxt = r_stall_cycles + 16'd1;
      end
      case (r_state)
        StIdle: begin
          w_state_nxt = StFetch;
          w_wcnt_nxt  = WaitInit;
        end
        StFetch, StStall: begin
          if (i_flush) begin
            // Redirect wins over any fetch due on this edge
            w_redirect_valid_nxt = 1'b1;
            w_ifid_flush_nxt     = 1'b1;
            w_redirect_addr_nxt  = i_branch_target;
            w_wcnt_nxt           = WaitInit;
            w_state_nxt          = w_stall ? StStall : StFetch;
          end else if (r_state == StFetch) begin
            if (r_wcnt != 4'd0) begin
              w_wcnt_nxt = r_wcnt - 4'd1;
            end else if (w_stall) begin
              w_state_nxt = StStall;
            end else begin
              w_pc_wd_nxt     = 1'b1;
              w_wcnt_nxt      = WaitInit;
              w_issue_cnt_nxt = r_issue_cnt + 32'd1;
            end
          end else if (!w_stall) begin
            // Memory wait already elapsed, so issue on the next edge
            w_state_nxt = StFetch;
            w_wcnt_nxt  = 4'd0;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end

    w_busy_nxt = (w_state_nxt != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_wcnt           <= WaitInit;
      r_pc_wd          <= 1'b0;
      r_ifid_flush     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_addr  <= '0;
      r_busy           <= 1'b0;
      r_issue_cnt      <= '0;
      r_stall_cycles   <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_wcnt           <= w_wcnt_nxt;
      r_pc_wd          <= w_pc_wd_nxt;
      r_ifid_flush     <= w_ifid_flush_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_addr  <= w_redirect_addr_nxt;
      r_busy           <= w_busy_nxt;
      r_issue_cnt      <= w_issue_cnt_nxt;
      r_stall_cycles   <= w_stall_cycles_nxt;
    end
  end

  assign o_pc_wd          = r_pc_wd;
  assign o_ifid_wd        = r_pc_wd;
  assign o_ifid_flush     = r_ifid_flush;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_addr  = r_redirect_addr;
  assign o_busy           = r_busy;
  assign o_issue_cnt      = r_issue_cnt;
  assign o_stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance with MEM_WAIT=1 scored against a queue of
// expected pc_wd cycles, one with MEM_WAIT=0 for zero-wait stall and counter saturation.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst1_n, ce1, flush1;
  logic [3:0]  stall1;
  logic [31:0] tgt1;
  logic        pc1, ifwd1, iff1, rv1, busy1;
  logic [31:0] ra1, ic1;
  logic [15:0] sc1;

  logic        rst0_n, ce0, flush0;
  logic [3:0]  stall0;
  logic [31:0] tgt0;
  logic        pc0, ifwd0, iff0, rv0, busy0;
  logic [31:0] ra0, ic0;
  logic [15:0] sc0;

  int n_cmp;
  int n_err;
  int cyc;
  int exp_q[$];

  fetch_ctrl #(.MEM_WAIT(1), .ADDR_W(32)) u_dut1 (
    .i_clk            (clk),
    .i_rst_n          (rst1_n),
    .i_ce             (ce1),
    .i_stall_req      (stall1),
    .i_flush          (flush1),
    .i_branch_target  (tgt1),
    .o_pc_wd          (pc1),
    .o_ifid_wd        (ifwd1),
    .o_ifid_flush     (iff1),
    .o_redirect_valid (rv1),
    .o_redirect_addr  (ra1),
    .o_busy           (busy1),
    .o_issue_cnt      (ic1),
    .o_stall_cycles   (sc1)
  );

  fetch_ctrl #(.MEM_WAIT(0), .ADDR_W(32)) u_dut0 (
    .i_clk            (clk),
    .i_rst_n          (rst0_n),
    .i_ce             (ce0),
    .i_stall_req      (stall0),
    .i_flush          (flush0),
    .i_branch_target  (tgt0),
    .o_pc_wd          (pc0),
    .o_ifid_wd        (ifwd0),
    .o_ifid_flush     (iff0),
    .o_redirect_valid (rv0),
    .o_redirect_addr  (ra0),
    .o_busy           (busy0),
    .o_issue_cnt      (ic0),
    .o_stall_cycles   (sc0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and score dut1 strobes against the queue
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pc1) begin
      if (exp_q.size() > 0) chk("pc_wd_cycle", 64'(cyc), 64'(exp_q.pop_front()));
      else chk("pc_wd_unexpected", {63'd0, pc1}, 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      chk("pc_wd_missing", {63'd0, pc1}, 64'd1);
      void'(exp_q.pop_front());
    end
    if (pc1 || ifwd1) chk("ifid_wd_match", {63'd0, ifwd1}, {63'd0, pc1});
    if (pc1 || rv1) chk("pc_wd_and_redirect", {63'd0, pc1 & rv1}, 64'd0);
  endtask

  initial begin
    clk = 1'b0;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst1_n = 1'b0; ce1 = 1'b0; flush1 = 1'b0; stall1 = 4'd0; tgt1 = '0;
    rst0_n = 1'b0; ce0 = 1'b0; flush0 = 1'b0; stall0 = 4'd0; tgt0 = '0;

    #2;
    chk("rst_pc_wd", {63'd0, pc1}, 64'd0);
    chk("rst_busy", {63'd0, busy1}, 64'd0);
    chk("rst_issue_cnt", 64'(ic1), 64'd0);
    chk("rst_stall_cycles", 64'(sc1), 64'd0);
    chk("rst_redirect_addr", 64'(ra1), 64'd0);
    chk("rst_redirect_valid", {63'd0, rv1}, 64'd0);

    // Reset/run: first strobe at cycle 3, then every 2nd cycle
    ce1 = 1'b1;
    #1 rst1_n = 1'b1;
    for (int c = 3; c <= 19; c += 2) exp_q.push_back(c);
    repeat (20) tick();
    chk("run_issue_cnt", 64'(ic1), 64'd9);
    chk("run_busy", {63'd0, busy1}, 64'd1);

    // Flush on the edge where a fetch would issue (cycle 21)
    flush1 = 1'b1; tgt1 = 32'h0000_1000;
    tick();
    chk("flush_redirect_valid", {63'd0, rv1}, 64'd1);
    chk("flush_ifid_flush", {63'd0, iff1}, 64'd1);
    chk("flush_redirect_addr", 64'(ra1), 64'h1000);
    chk("flush_pc_wd", {63'd0, pc1}, 64'd0);
    flush1 = 1'b0;
    exp_q.push_back(23);
    tick();
    chk("flush_rv_pulse", {63'd0, rv1}, 64'd0);
    chk("flush_iff_pulse", {63'd0, iff1}, 64'd0);
    tick();
    chk("flush_issue_cnt", 64'(ic1), 64'd10);

    // Flush while stalled: stays in STALL, no strobe until release
    stall1 = 4'b0001;
    tick();
    tick();
    chk("stall_busy", {63'd0, busy1}, 64'd1);
    flush1 = 1'b1; tgt1 = 32'h0000_2000;
    tick();
    chk("sflush_redirect_valid", {63'd0, rv1}, 64'd1);
    chk("sflush_redirect_addr", 64'(ra1), 64'h2000);
    flush1 = 1'b0;
    tick();
    chk("sflush_rv_pulse", {63'd0, rv1}, 64'd0);
    tick();
    chk("sflush_stall_cycles", 64'(sc1), 64'd3);
    stall1 = 4'b0000;
    exp_q.push_back(30);
    tick();
    chk("release_stall_cycles", 64'(sc1), 64'd4);
    tick();
    chk("release_issue_cnt", 64'(ic1), 64'd11);

    // ce drop mid-wait: idle, counters and redirect address held
    ce1 = 1'b0;
    tick();
    chk("ce_busy", {63'd0, busy1}, 64'd0);
    tick();
    tick();
    chk("ce_issue_held", 64'(ic1), 64'd11);
    chk("ce_stall_held", 64'(sc1), 64'd4);
    chk("ce_addr_held", 64'(ra1), 64'h2000);
    ce1 = 1'b1;
    exp_q.push_back(36);
    tick();
    chk("ce_resume_busy", {63'd0, busy1}, 64'd1);
    tick();
    tick();

    // Asynchronous reset while pc_wd is high
    #2 rst1_n = 1'b0;
    #1;
    chk("arst_pc_wd", {63'd0, pc1}, 64'd0);
    chk("arst_ifid_wd", {63'd0, ifwd1}, 64'd0);
    chk("arst_issue_cnt", 64'(ic1), 64'd0);
    chk("arst_stall_cycles", 64'(sc1), 64'd0);
    chk("arst_redirect_addr", 64'(ra1), 64'd0);
    chk("arst_busy", {63'd0, busy1}, 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Zero wait states: strobe every unstalled cycle
    ce0 = 1'b1;
    #1 rst0_n = 1'b1;
    tick();
    tick();
    chk("zw_pc_wd_a", {63'd0, pc0}, 64'd1);
    tick();
    chk("zw_pc_wd_b", {63'd0, pc0}, 64'd1);
    chk("zw_issue_cnt", 64'(ic0), 64'd2);
    stall0 = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zw_stalled_pc_wd", {63'd0, pc0}, 64'd0);
    end
    stall0 = 4'b0000;
    tick();
    chk("zw_release_pc_wd", {63'd0, pc0}, 64'd0);
    chk("zw_stall_cycles", 64'(sc0), 64'd5);
    tick();
    chk("zw_resume_pc_wd", {63'd0, pc0}, 64'd1);
    chk("zw_resume_issue", 64'(ic0), 64'd3);

    // Saturation of the stall counter
    stall0 = 4'b1000;
    repeat (70000) tick();
    chk("sat_stall_cycles", 64'(sc0), 64'hFFFF);
    chk("sat_pc_wd", {63'd0, pc0}, 64'd0);
    chk("sat_issue_held", 64'(ic0), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
